tcdm_rsp_packer: RTL and testbench

TCDM_RSP_PACKER -- requirements
Module: tcdm_rsp_packer

---
 rtl/tcdm_rsp_packer.sv | 133 +++++++++++++
 tb/tb_tcdm_rsp_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_rsp_packer.sv
// tcdm_rsp_packer: gathers per-lane TCDM read responses into per-lane FIFOs
// and releases one packed word (lane 0 in the LSBs) when every lane has data.
// Lane credit (lane_ready_o) accounts for buffered plus inflight requests.
// Optional macro TCDM_RSP_PACKER_ERR_CHECK_EN builds the sticky protocol-error
// detector; without it error_o is tied to 0.
module tcdm_rsp_packer #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned NumLanes        = 4,
  parameter int unsigned FifoDepth       = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic [NumLanes-1:0]                 req_fire_i,
  output logic [NumLanes-1:0]                 lane_ready_o,
  input  logic [NumLanes-1:0]                 rsp_valid_i,
  input  logic [NumLanes*NarrowDataWidth-1:0] rsp_data_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [NumLanes*NarrowDataWidth-1:0] out_data_o,
  output logic                                error_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned CW = $clog2(FifoDepth + 1);
  localparam logic [CW-1:0] DEPTH   = CW'(FifoDepth);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FifoDepth);

  logic [NarrowDataWidth-1:0] mem_q  [NumLanes][FifoDepth];
  logic [AW-1:0]              wptr_q [NumLanes];
  logic [AW-1:0]              rptr_q [NumLanes];
  logic [CW-1:0]              occ_q  [NumLanes];
  logic [CW-1:0]              inf_q  [NumLanes];

  logic [NumLanes-1:0] lane_nonempty;
  logic [NumLanes-1:0] push_ok;
  logic                pop;

  // Output valid, pop, accepted pushes, lane credit and head-of-line data.
  always_comb begin
    lane_nonempty = '0;
    lane_ready_o  = '0;
    push_ok       = '0;
    out_data_o    = '0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      lane_nonempty[l] = (occ_q[l] != '0);
      lane_ready_o[l]  = ({1'b0, occ_q[l]} + {1'b0, inf_q[l]}) < DEPTH_W;
    end
    out_valid_o = &lane_nonempty;
    pop         = out_valid_o & out_ready_i;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      // A full lane still accepts a push when it pops in the same cycle.
      push_ok[l] = rsp_valid_i[l] & ((occ_q[l] != DEPTH) | pop);
      if (out_valid_o) begin
        out_data_o[l*NarrowDataWidth +: NarrowDataWidth] = mem_q[l][rptr_q[l]];
      end
    end
  end

  // FIFO storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < NumLanes; l++) begin
      if (!clear_i && push_ok[l]) begin
        mem_q[l][wptr_q[l]] <= rsp_data_i[l*NarrowDataWidth +: NarrowDataWidth];
      end
    end
  end

  // Pointers, occupancy and inflight counters per lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        occ_q[l]  <= '0;
        inf_q[l]  <= '0;
      end
    end else if (clear_i) begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        occ_q[l]  <= '0;
        inf_q[l]  <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        if (push_ok[l]) wptr_q[l] <= wptr_q[l] + AW'(1);
        if (pop)        rptr_q[l] <= rptr_q[l] + AW'(1);
        case ({push_ok[l], pop})
          2'b10:   occ_q[l] <= occ_q[l] + CW'(1);
          2'b01:   occ_q[l] <= occ_q[l] - CW'(1);
          default: occ_q[l] <= occ_q[l];
        endcase
        case ({req_fire_i[l], rsp_valid_i[l]})
          2'b10:   if (inf_q[l] != DEPTH) inf_q[l] <= inf_q[l] + CW'(1);
          2'b01:   if (inf_q[l] != '0)    inf_q[l] <= inf_q[l] - CW'(1);
          default: inf_q[l] <= inf_q[l];
        endcase
      end
    end
  end

`ifdef TCDM_RSP_PACKER_ERR_CHECK_EN
  logic [NumLanes-1:0] err_event;
  logic                err_q;

  // Per-lane protocol errors: dropped push, inflight saturation or underflow.
  always_comb begin
    err_event = '0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      err_event[l] = (rsp_valid_i[l] & ~push_ok[l])
                   | (req_fire_i[l] & ~rsp_valid_i[l] & (inf_q[l] == DEPTH))
                   | (rsp_valid_i[l] & ~req_fire_i[l] & (inf_q[l] == '0));
    end
  end

  // Sticky error flag, cleared only by clear_i or reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (|err_event) begin
      err_q <= 1'b1;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcdm_rsp_packer.sv
// Testbench for tcdm_rsp_packer: directed vector table, mid-cycle reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_tcdm_rsp_packer;

  localparam int W = 64;
  localparam int L = 4;
  localparam int D = 4;
`ifdef TCDM_RSP_PACKER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_ni = 1'b1;
  logic           clear = 1'b0;
  logic [L-1:0]   fire = '0;
  logic [L-1:0]   lrdy;
  logic [L-1:0]   rsp = '0;
  logic [L*W-1:0] rdata = '0;
  logic           ov;
  logic           ordy = 1'b0;
  logic [L*W-1:0] odata;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  tcdm_rsp_packer #(
    .NarrowDataWidth(W),
    .NumLanes(L),
    .FifoDepth(D)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .clear_i(clear),
    .req_fire_i(fire),
    .lane_ready_o(lrdy),
    .rsp_valid_i(rsp),
    .rsp_data_i(rdata),
    .out_valid_o(ov),
    .out_ready_i(ordy),
    .out_data_o(odata),
    .error_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fire;
    logic [3:0]  rsp;
    logic [31:0] tags;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [3:0]  elr;
    logic [31:0] etags;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: per-lane data queues, inflight counts, error flag.
  logic [W-1:0] mq[L][$];
  int           minf[L];
  bit           merr;

  function automatic logic [L*W-1:0] expand(input logic [31:0] tags);
    logic [L*W-1:0] r;
    r = '0;
    for (int l = 0; l < L; l++)
      for (int b = 0; b < W/8; b++)
        r[l*W + b*8 +: 8] = tags[l*8 +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] f, input logic [3:0] r,
                              input logic [31:0] t, input logic rd, input logic c,
                              input logic ev, input logic [3:0] elr,
                              input logic [31:0] et, input logic ee);
    vec_t v;
    v.fire = f; v.rsp = r; v.tags = t; v.rdy = rd; v.clr = c;
    v.ev = ev; v.elr = elr; v.etags = et; v.eerr = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [L*W-1:0] act,
                       input logic [L*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < L; l++) begin
      mq[l].delete();
      minf[l] = 0;
    end
    merr = 1'b0;
  endtask

  task automatic model_check(input string tag);
    bit             all_ne;
    logic [L-1:0]   elr;
    logic [L*W-1:0] ed;
    all_ne = 1'b1;
    ed = '0;
    for (int l = 0; l < L; l++) begin
      if (mq[l].size() == 0) all_ne = 1'b0;
      elr[l] = (mq[l].size() + minf[l] < D);
    end
    if (all_ne)
      for (int l = 0; l < L; l++) ed[l*W +: W] = mq[l][0];
    check({tag, "_valid"}, {255'b0, ov}, {255'b0, all_ne});
    check({tag, "_lane_ready"}, {252'b0, lrdy}, {252'b0, elr});
    check({tag, "_data"}, odata, ed);
    check({tag, "_error"}, {255'b0, err}, {255'b0, merr});
  endtask

  task automatic model_step();
    bit all_ne;
    bit pop;
    bit ev;
    if (clear) begin
      model_reset();
      return;
    end
    all_ne = 1'b1;
    for (int l = 0; l < L; l++) if (mq[l].size() == 0) all_ne = 1'b0;
    pop = all_ne && ordy;
    ev = 1'b0;
    for (int l = 0; l < L; l++) begin
      if (pop) void'(mq[l].pop_front());
      if (rsp[l]) begin
        if (mq[l].size() < D) mq[l].push_back(rdata[l*W +: W]);
        else ev = 1'b1;
      end
      if (fire[l] && !rsp[l]) begin
        if (minf[l] == D) ev = 1'b1;
        else minf[l]++;
      end
      if (rsp[l] && !fire[l]) begin
        if (minf[l] == 0) ev = 1'b1;
        else minf[l]--;
      end
    end
    if (ERR_EN && ev) merr = 1'b1;
  endtask

  task automatic cycle(input logic [3:0] f, input logic [3:0] r,
                       input logic [L*W-1:0] d, input logic rd, input logic c,
                       input string tag);
    fire = f; rsp = r; rdata = d; ordy = rd; clear = c;
    #3;
    model_check(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Directed table: expectations reflect state before each row's clock edge.
    tbl.push_back(mk(4'hF, 4'h0, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'hF, 32'h44332211, 0, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        0, 0, 1, 4'hF, 32'h44332211, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 32'h44332211, 0));
    tbl.push_back(mk(4'hF, 4'h0, 32'h0,        1, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'h7, 32'h00a3a2a1, 1, 0, 0, 4'hF, 32'h0,        0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(4'h0, 4'h0, 32'h0,      1, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'h8, 32'ha4000000, 1, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 32'ha4a3a2a1, 0));
    tbl.push_back(mk(4'hF, 4'h0, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'hF, 4'hF, 32'h10101010, 0, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'hF, 4'hF, 32'h20202020, 0, 0, 1, 4'hF, 32'h10101010, 0));
    tbl.push_back(mk(4'hF, 4'hF, 32'h30303030, 0, 0, 1, 4'hF, 32'h10101010, 0));
    tbl.push_back(mk(4'h0, 4'hF, 32'h40404040, 0, 0, 1, 4'h0, 32'h10101010, 0));
    tbl.push_back(mk(4'hF, 4'hF, 32'h50505050, 1, 0, 1, 4'h0, 32'h10101010, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'h0, 32'h20202020, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 32'h30303030, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 32'h40404040, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 32'h50505050, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(4'hF, 4'h0, 32'h0,      0, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'hF, 32'h71717171, 0, 0, 0, 4'h0, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'hF, 32'h72727272, 0, 0, 1, 4'h0, 32'h71717171, 0));
    tbl.push_back(mk(4'h0, 4'hF, 32'h73737373, 0, 0, 1, 4'h0, 32'h71717171, 0));
    tbl.push_back(mk(4'h0, 4'hF, 32'h74747474, 0, 0, 1, 4'h0, 32'h71717171, 0));
    tbl.push_back(mk(4'h0, 4'h4, 32'h00ee0000, 0, 0, 1, 4'h0, 32'h71717171, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        0, 0, 1, 4'h0, 32'h71717171, ERR_EN));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'h0, 32'h71717171, ERR_EN));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 32'h72727272, ERR_EN));
    tbl.push_back(mk(4'hF, 4'hF, 32'h99999999, 1, 1, 1, 4'hF, 32'h73737373, ERR_EN));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0));

    // Asynchronous reset, checked before any clock edge.
    #1 rst_ni = 1'b0;
    #1;
    check("reset_valid", {255'b0, ov}, '0);
    check("reset_lane_ready", {252'b0, lrdy}, {252'b0, 4'hF});
    check("reset_data", odata, '0);
    check("reset_error", {255'b0, err}, '0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    foreach (tbl[i]) begin
      fire  = tbl[i].fire;
      rsp   = tbl[i].rsp;
      rdata = expand(tbl[i].tags);
      ordy  = tbl[i].rdy;
      clear = tbl[i].clr;
      #3;
      check($sformatf("tbl%0d_valid", i), {255'b0, ov}, {255'b0, tbl[i].ev});
      check($sformatf("tbl%0d_lane_ready", i), {252'b0, lrdy}, {252'b0, tbl[i].elr});
      check($sformatf("tbl%0d_data", i), odata, expand(tbl[i].etags));
      check($sformatf("tbl%0d_error", i), {255'b0, err}, {255'b0, tbl[i].eerr});
      @(posedge clk);
      #1;
    end

    // Reset asserted between edges with three entries buffered per lane.
    model_reset();
    cycle(4'hF, 4'h0, '0, 1'b0, 1'b0, "fill0");
    cycle(4'hF, 4'hF, expand(32'hc1c1c1c1), 1'b0, 1'b0, "fill1");
    cycle(4'hF, 4'hF, expand(32'hc2c2c2c2), 1'b0, 1'b0, "fill2");
    cycle(4'h0, 4'hF, expand(32'hc3c3c3c3), 1'b0, 1'b0, "fill3");
    fire = '0; rsp = '0; ordy = 1'b0; clear = 1'b0;
    #1;
    model_check("buffered");
    #1 rst_ni = 1'b0;
    #1;
    check("midreset_valid", {255'b0, ov}, '0);
    check("midreset_lane_ready", {252'b0, lrdy}, {252'b0, 4'hF});
    check("midreset_data", odata, '0);
    check("midreset_error", {255'b0, err}, '0);
    model_reset();
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [L*W-1:0] d;
      for (int k = 0; k < L*W/32; k++) d[k*32 +: 32] = $urandom;
      cycle(4'($urandom), 4'($urandom), d, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 99) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
